// File: rtl/shift_pla_pkg.sv
// Shared definitions for the shift-only piecewise-linear activation pipe:
// mode encodings and output-format helper functions.
package shift_pla_pkg;

    typedef enum logic {
        MODE_TANH = 1'b0,
        MODE_SIGM = 1'b1
    } mode_e;

    function automatic int unsigned out_frac_bits(input int unsigned w_out);
        return w_out - 1;
    endfunction

    // Largest positive Q1.OUT_F value; also the symmetric saturation magnitude.
    function automatic int unsigned sat_value(input int unsigned w_out);
        return (32'd1 << (w_out - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/shift_pla_act_pipe_if.sv
// Valid/ready stream bundle for the activation pipe: one input and one
// output channel, N_CH packed words each.
interface shift_pla_act_pipe_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W_IN  = 16,
    parameter int unsigned W_OUT = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic [N_CH*W_IN-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_CH*W_OUT-1:0]   out_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_pla_lane.sv
// One channel of the activation: magnitude/segment extraction, shift, then
// sign restore, saturation and tanh/sigmoid post-processing.
module shift_pla_lane
    import shift_pla_pkg::*;
#(
    parameter int unsigned W_IN  = 16,
    parameter int unsigned IN_I  = 4,
    parameter int unsigned W_OUT = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              en1,
    input  logic              en2,
    input  logic              en3,
    input  logic [W_IN-1:0]   x,
    input  mode_e             mode_s1,
    input  mode_e             mode_s3,
    output logic [W_OUT-1:0]  y
);
    localparam int unsigned IN_F  = W_IN - IN_I;
    localparam int unsigned OUT_F = out_frac_bits(W_OUT);
    localparam int unsigned KW    = IN_I + 2;
    localparam logic [OUT_F:0]   ONE   = {1'b1, {OUT_F{1'b0}}};
    localparam logic [KW-1:0]    K_MAX = KW'(OUT_F);
    localparam logic [W_OUT-1:0] SAT   = W_OUT'(sat_value(W_OUT));
    localparam logic [W_OUT-1:0] HALF  = W_OUT'(32'd1 << (OUT_F - 1));

    // Magnitude is one bit wider so the most negative input stays exact.
    logic [W_IN:0]    mag;
    logic [W_IN+1:0]  t;
    logic [OUT_F-1:0] r;
    logic [OUT_F-1:0] r_half;
    logic [OUT_F:0]   inner_c;

    always_comb begin
        mag = x[W_IN-1] ? ({1'b0, ~x} + (W_IN+1)'(1)) : {1'b0, x};
        t   = (mode_s1 == MODE_SIGM) ? {1'b0, mag} : {mag, 1'b0};
    end

    generate
        if (IN_F >= OUT_F) begin : g_trunc
            assign r = t[IN_F-1 -: OUT_F];
        end else begin : g_ext
            assign r = {t[IN_F-1:0], {(OUT_F-IN_F){1'b0}}};
        end
    endgenerate

    assign r_half  = r >> 1;
    assign inner_c = ONE - {1'b0, r_half};

    logic            neg1, neg2;
    logic [KW-1:0]   k1;
    logic [OUT_F:0]  inner1, v2, v_c;

    assign v_c = (k1 > K_MAX) ? '0 : (inner1 >> k1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            neg1   <= 1'b0;
            k1     <= '0;
            inner1 <= '0;
            neg2   <= 1'b0;
            v2     <= '0;
        end else begin
            if (en1) begin
                neg1   <= x[W_IN-1];
                k1     <= t[W_IN+1:IN_F];
                inner1 <= inner_c;
            end
            if (en2) begin
                neg2 <= neg1;
                v2   <= v_c;
            end
        end
    end

    logic [W_OUT-1:0]        y_full, y_mag, y_c;
    logic signed [W_OUT-1:0] ys, ys_half;

    always_comb begin
        y_full  = ONE - v2;
        y_mag   = (y_full == ONE) ? SAT : y_full;
        ys      = neg2 ? -y_mag : y_mag;
        ys_half = ys >>> 1;
        y_c     = (mode_s3 == MODE_SIGM) ? (HALF + ys_half) : ys;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            y <= '0;
        end else if (en3) begin
            y <= y_c;
        end
    end
endmodule

// File: rtl/shift_pla_act_pipe.sv
// Three-stage multi-channel tanh/sigmoid unit: valid/ready control, mode
// pipeline and N_CH parallel lanes.
module shift_pla_act_pipe
    import shift_pla_pkg::*;
#(
    parameter int unsigned W_IN  = 16,
    parameter int unsigned IN_I  = 4,
    parameter int unsigned W_OUT = 16,
    parameter int unsigned N_CH  = 4
) (
    input  logic              clock,
    input  logic              resetn,
    shift_pla_act_pipe_if.slave bus
);
    logic  v1, v2, v3;
    logic  adv1, adv2, adv3;
    logic  en1, en2, en3;
    mode_e mode1, mode2;
    mode_e in_mode_e;

    // Each stage moves when empty or when the stage after it moves.
    assign adv3 = !v3 || bus.out_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    assign en1 = adv1 && bus.in_valid;
    assign en2 = adv2 && v1;
    assign en3 = adv3 && v2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3;
    assign in_mode_e     = mode_e'(bus.in_mode);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            mode1 <= MODE_TANH;
            mode2 <= MODE_TANH;
        end else begin
            if (adv1) v1 <= bus.in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
            if (en1)  mode1 <= in_mode_e;
            if (en2)  mode2 <= mode1;
        end
    end

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_lane
            shift_pla_lane #(
                .W_IN  (W_IN),
                .IN_I  (IN_I),
                .W_OUT (W_OUT)
            ) u_lane (
                .clock   (clock),
                .resetn  (resetn),
                .en1     (en1),
                .en2     (en2),
                .en3     (en3),
                .x       (bus.in_data[c*W_IN +: W_IN]),
                .mode_s1 (in_mode_e),
                .mode_s3 (mode2),
                .y       (bus.out_data[c*W_OUT +: W_OUT])
            );
        end
    endgenerate
endmodule
